// File: rtl/ca90_item_pkg.sv
// ============================================================================
//  Module      : ca90_item_pkg
//  Description : Shared types for the CA90 item generator. Defines the
//                controller state encoding used by ca90_item_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ca90_item_pkg;

  // Controller states: wait for a request, iterate CA90, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fixed_ca90_unit.sv
// ============================================================================
//  Module      : fixed_ca90_unit
//  Description : One combinational CA90 (rule 90) step on a cyclic vector:
//                o_hv[i] = i_hv[(i+ShiftAmt) mod D] ^ i_hv[(i-ShiftAmt) mod D]
//  Ports       : i_hv  - input vector (Dimension bits)
//                o_hv  - vector after one CA90 step (Dimension bits)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_ca90_unit #(
  parameter int Dimension = 512,
  parameter int ShiftAmt  = 1
) (
  input  logic [Dimension-1:0] i_hv,
  output logic [Dimension-1:0] o_hv
);

  // Index arithmetic is resolved at elaboration; each output bit is a
  // single XOR of two fixed input bits.
  for (genvar gi = 0; gi < Dimension; gi++) begin : g_bit
    assign o_hv[gi] = i_hv[(gi + ShiftAmt) % Dimension]
                    ^ i_hv[(gi + Dimension - ShiftAmt) % Dimension];
  end

endmodule

`default_nettype wire

// File: rtl/ca90_item_gen.sv
// ============================================================================
//  Module      : ca90_item_gen
//  Description : Produces item hypervectors as CA90^idx(base). The last
//                generated state is cached so that a request for an index at
//                or above the cached one only iterates the difference.
//  Ports       : clk_i / rst_i      - clock, synchronous active-high reset
//                base_hv_i          - base hypervector
//                base_update_i      - pulse: base changed, drop the cache
//                req_valid_i/ready_o/idx_i - request handshake and index
//                item_valid_o/ready_i/hv_o - result handshake and vector
//                busy_o             - high while stepping or presenting
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ca90_item_gen
  import ca90_item_pkg::*;
#(
  parameter  int HVDimension = 512,
  parameter  int ShiftAmt    = 1,
  parameter  int NumItems    = 1024,
  localparam int IdxWidth    = $clog2(NumItems)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [HVDimension-1:0] base_hv_i,
  input  logic                   base_update_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [IdxWidth-1:0]    req_idx_i,
  output logic                   item_valid_o,
  input  logic                   item_ready_i,
  output logic [HVDimension-1:0] item_hv_o,
  output logic                   busy_o
);

  state_e                 r_fsm,       w_fsm_nxt;
  logic [HVDimension-1:0] r_state_hv,  w_state_hv_nxt;
  logic [IdxWidth-1:0]    r_cur_idx,   w_cur_idx_nxt;
  logic [IdxWidth-1:0]    r_rem,       w_rem_nxt;
  logic                   r_cache_vld, w_cache_vld_nxt;
  logic [HVDimension-1:0] w_step_hv;
  logic                   w_incr;

  fixed_ca90_unit #(
    .Dimension (HVDimension),
    .ShiftAmt  (ShiftAmt)
  ) u_ca90 (
    .i_hv (r_state_hv),
    .o_hv (w_step_hv)
  );

  // The cached state can be reused only if it is still derived from the
  // current base and lies at or below the requested index.
  assign w_incr = r_cache_vld && !base_update_i && (req_idx_i >= r_cur_idx);

  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_state_hv_nxt  = r_state_hv;
    w_cur_idx_nxt   = r_cur_idx;
    w_rem_nxt       = r_rem;
    w_cache_vld_nxt = r_cache_vld;

    // A base change always invalidates the cache; the reload branch below
    // re-validates it when the new base is captured in the same cycle.
    if (base_update_i) begin
      w_cache_vld_nxt = 1'b0;
    end

    case (r_fsm)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (w_incr) begin
            w_rem_nxt = req_idx_i - r_cur_idx;
          end else begin
            w_state_hv_nxt  = base_hv_i;
            w_cur_idx_nxt   = '0;
            w_rem_nxt       = req_idx_i;
            w_cache_vld_nxt = 1'b1;
          end
          w_fsm_nxt = (w_rem_nxt == '0) ? ST_OUT : ST_STEP;
        end
      end
      ST_STEP: begin
        w_state_hv_nxt = w_step_hv;
        w_cur_idx_nxt  = r_cur_idx + IdxWidth'(1);
        w_rem_nxt      = r_rem - IdxWidth'(1);
        if (r_rem == IdxWidth'(1)) begin
          w_fsm_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (item_ready_i) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm       <= ST_IDLE;
      r_state_hv  <= '0;
      r_cur_idx   <= '0;
      r_rem       <= '0;
      r_cache_vld <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state_hv  <= w_state_hv_nxt;
      r_cur_idx   <= w_cur_idx_nxt;
      r_rem       <= w_rem_nxt;
      r_cache_vld <= w_cache_vld_nxt;
    end
  end

  assign req_ready_o  = (r_fsm == ST_IDLE);
  assign item_valid_o = (r_fsm == ST_OUT);
  assign busy_o       = (r_fsm == ST_STEP) || (r_fsm == ST_OUT);
  assign item_hv_o    = r_state_hv;

endmodule

`default_nettype wire

// File: tb/tb_ca90_item_gen.sv
// ============================================================================
//  Module      : tb_ca90_item_gen
//  Description : Self-checking bench for ca90_item_gen: directed sequences,
//                a vector table and randomized requests against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ca90_item_gen;

  localparam int D  = 512;
  localparam int S  = 1;
  localparam int N  = 1024;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [D-1:0]  base_hv = '0;
  logic          base_update = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic [IW-1:0] req_idx = '0;
  logic          item_valid_o;
  logic          item_ready = 1'b0;
  logic [D-1:0]  item_hv_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: base captured at the last reload, and the
  // index of the last delivered item while that base is still valid.
  logic [D-1:0] m_base = '0;
  bit           m_vld  = 1'b0;
  int           m_idx  = 0;

  ca90_item_gen #(.HVDimension(D), .ShiftAmt(S), .NumItems(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .base_hv_i    (base_hv),
    .base_update_i(base_update),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_idx_i    (req_idx),
    .item_valid_o (item_valid_o),
    .item_ready_i (item_ready),
    .item_hv_o    (item_hv_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] ca90(input logic [D-1:0] v);
    logic [D-1:0] r;
    for (int i = 0; i < D; i++) r[i] = v[(i + S) % D] ^ v[(i - S + D) % D];
    return r;
  endfunction

  function automatic logic [D-1:0] ca90n(input logic [D-1:0] v, input int n);
    logic [D-1:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = ca90(r);
    return r;
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] r;
    for (int i = 0; i < D / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [D-1:0] act,
                     input logic [D-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model(input int idx, input bit upd, input logic [D-1:0] base_now,
                       output int lat, output logic [D-1:0] hv);
    if (m_vld && !upd && idx >= m_idx) begin
      lat = idx - m_idx + 1;
    end else begin
      m_base = base_now;
      lat    = idx + 1;
    end
    m_vld = 1'b1;
    m_idx = idx;
    hv    = ca90n(m_base, idx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    m_vld = 1'b0;
  endtask

  // Issues one request from a negedge and checks latency, data, stability
  // during a held-off result and the return to idle. Optionally updates the
  // base in the accept cycle (upd) or mid-flight (mid_upd cycles later).
  task automatic do_req(input int idx, input bit upd, input logic [D-1:0] nb,
                        input int hold, input int mid_upd, input logic [D-1:0] mid_base,
                        input int exp_lat, input logic [D-1:0] exp_hv, input string nm);
    int w;
    int lat;
    bit got;
    w = 0;
    while (!req_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk(req_ready_o == 1'b1, {nm, "_ready"}, D'(req_ready_o), D'(1));
    req_valid = 1'b1;
    req_idx   = IW'(idx);
    if (upd) begin
      base_hv     = nb;
      base_update = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    base_update = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 1100) begin
      @(negedge clk);
      lat++;
      base_update = 1'b0;
      if (item_valid_o) got = 1'b1;
      else if (lat == mid_upd) begin
        base_hv     = mid_base;
        base_update = 1'b1;
      end
    end
    chk(got && lat == exp_lat, {nm, "_latency"}, D'(lat), D'(exp_lat));
    chk(item_hv_o == exp_hv, {nm, "_hv"}, item_hv_o, exp_hv);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk(item_valid_o && !req_ready_o && item_hv_o == exp_hv, {nm, "_hold"},
          item_hv_o, exp_hv);
    end
    item_ready = 1'b1;
    @(posedge clk);
    #1 item_ready = 1'b0;
    @(negedge clk);
    chk(!item_valid_o && req_ready_o, {nm, "_idle"},
        D'({item_valid_o, req_ready_o}), D'(2'b01));
  endtask

  typedef struct {
    int idx;
    int lat;
  } vec_t;

  initial begin
    vec_t         tbl [5];
    logic [D-1:0] b1;
    logic [D-1:0] b2;
    logic [D-1:0] exp_hv;
    logic [D-1:0] nb;
    int           lat;
    int           vcount;
    bit           upd;

    tbl[0] = '{idx: 3, lat: 4};   // reload from fresh base
    tbl[1] = '{idx: 5, lat: 3};   // incremental, 2 steps
    tbl[2] = '{idx: 2, lat: 3};   // below cache -> reload
    tbl[3] = '{idx: 2, lat: 1};   // same index, no steps
    tbl[4] = '{idx: 9, lat: 8};   // incremental, 7 steps

    do_reset();
    chk(req_ready_o == 1'b1, "rst_ready", D'(req_ready_o), D'(1));
    chk(item_valid_o == 1'b0, "rst_valid", D'(item_valid_o), D'(0));
    chk(item_hv_o == '0, "rst_hv", item_hv_o, '0);
    chk(busy_o == 1'b0, "rst_busy", D'(busy_o), D'(0));

    // Index 0 returns the base itself.
    base_hv = D'(1);
    model(0, 1'b0, base_hv, lat, exp_hv);
    do_req(0, 1'b0, '0, 0, -1, '0, 1, D'(1), "idx0");

    // Single step from a one-hot base.
    do_reset();
    exp_hv = '0;
    exp_hv[1]   = 1'b1;
    exp_hv[D-1] = 1'b1;
    model(1, 1'b0, base_hv, lat, nb);
    do_req(1, 1'b0, '0, 0, -1, '0, 2, exp_hv, "idx1");

    // Vector table against a random base.
    do_reset();
    base_hv = rand_hv();
    for (int t = 0; t < 5; t++) begin
      model(tbl[t].idx, 1'b0, base_hv, lat, exp_hv);
      do_req(tbl[t].idx, 1'b0, '0, 0, -1, '0, tbl[t].lat, exp_hv,
             $sformatf("tbl%0d", t));
    end

    // Consumer stalls ten cycles.
    model(12, 1'b0, base_hv, lat, exp_hv);
    do_req(12, 1'b0, '0, 10, -1, '0, 4, exp_hv, "stall");

    // Base changes while stepping: in-flight item keeps the old base,
    // the next one reloads from the new base.
    do_reset();
    b1 = rand_hv();
    b2 = rand_hv();
    base_hv = b1;
    model(6, 1'b0, base_hv, lat, exp_hv);
    do_req(6, 1'b0, '0, 0, 3, b2, 7, ca90n(b1, 6), "midupd_old");
    m_vld = 1'b0;
    model(7, 1'b0, base_hv, lat, exp_hv);
    do_req(7, 1'b0, '0, 0, -1, '0, 8, ca90n(b2, 7), "midupd_new");

    // Reset while stepping aborts the item.
    req_valid = 1'b1;
    req_idx   = IW'(10);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_vld = 1'b0;
    @(negedge clk);
    chk(req_ready_o && !item_valid_o && !busy_o && item_hv_o == '0, "midrst_out",
        item_hv_o, '0);
    vcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (item_valid_o) vcount++;
    end
    chk(vcount == 0, "midrst_novalid", D'(vcount), D'(0));
    model(0, 1'b0, base_hv, lat, exp_hv);
    do_req(0, 1'b0, '0, 0, -1, '0, 1, base_hv, "midrst_idx0");

    // Randomized requests, sometimes with a base update in the accept cycle.
    for (int r = 0; r < 25; r++) begin
      int idx;
      int hold;
      idx  = $urandom_range(0, 40);
      hold = $urandom_range(0, 3);
      upd  = ($urandom_range(0, 3) == 0);
      nb   = upd ? rand_hv() : base_hv;
      model(idx, upd, nb, lat, exp_hv);
      do_req(idx, upd, nb, hold, -1, '0, lat, exp_hv, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ca90_item_gen.md
CA90_ITEM_GEN -- requirements
Module: ca90_item_gen

Interface
REQ-001 SHALL have parameter HVDimension, default 512: hypervector width in bits.
REQ-002 SHALL have parameter ShiftAmt, default 1: CA90 rotation distance; 1 <= ShiftAmt < HVDimension/2.
REQ-003 SHALL have parameter NumItems, default 1024: number of addressable items; power of two, >= 2; IdxWidth = $clog2(NumItems).
REQ-004 SHALL have ports, clock and reset first: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- base_hv_i  in  HVDimension  base HV from the hierarchical CA90 base generator
- base_update_i  in  1  one-cycle pulse: base_hv_i has changed, invalidate the cached state
- req_valid_i  in  1  item request valid
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
- req_idx_i  in  IdxWidth  requested item index
- item_valid_o  out  1  item_hv_o valid
- item_ready_i  in  1  consumer ready
- item_hv_o  out  HVDimension  item hypervector = CA90 applied req_idx_i times to base_hv_i
- busy_o  out  1  high in STEP and OUT

Function
REQ-005 SHALL define one CA90 step as out[i] = v[(i+ShiftAmt) mod D] XOR v[(i-ShiftAmt) mod D], with D = HVDimension (rotate-left XOR rotate-right).
REQ-006 SHALL hold the state register state_q (HVDimension), cur_idx_q (IdxWidth), rem_q (IdxWidth) and cache_vld_q (1).
REQ-007 SHALL implement FSM states IDLE, STEP and OUT; req_ready_o = 1 only in IDLE.
REQ-008 On accept in IDLE, when cache_vld_q && !base_update_i && req_idx_i >= cur_idx_q: rem_q <= req_idx_i - cur_idx_q, and state_q is kept (incremental path).
REQ-009 On accept in IDLE otherwise: state_q <= base_hv_i (value in the accept cycle), cur_idx_q <= 0, rem_q <= req_idx_i, cache_vld_q <= 1 (reload path).
REQ-010 After accept, SHALL go to OUT if the computed remaining count is 0, else to STEP.
REQ-011 In STEP, each cycle: state_q <= CA90(state_q), cur_idx_q++, rem_q--; when rem_q == 1, SHALL go to OUT.
REQ-012 In OUT: item_valid_o = 1 and item_hv_o = state_q, held stable until item_ready_i; on handshake SHALL go to IDLE.
REQ-013 Latency: item_valid_o SHALL rise k+1 cycles after the accept edge, where k is the number of steps.
REQ-014 No new request SHALL be accepted in the OUT handshake cycle; back-to-back throughput is one item per k+2 cycles.
REQ-015 base_update_i in STEP or OUT SHALL clear cache_vld_q, and the in-flight item SHALL complete from its original base.
REQ-016 base_update_i in IDLE with a simultaneous accept SHALL force the reload path using the current base_hv_i.
REQ-017 cur_idx_q SHALL never exceed NumItems-1; index wrap cannot occur because req_idx_i <= NumItems-1.
REQ-018 item_valid_o SHALL be 0 outside OUT, and item_hv_o SHALL equal state_q at all times.

Reset
REQ-019 rst_i high at a clock edge SHALL set: FSM to IDLE, state_q = 0, cur_idx_q = 0, rem_q = 0, cache_vld_q = 0.
REQ-020 Resulting outputs after reset: req_ready_o = 1, item_valid_o = 0, item_hv_o = 0, busy_o = 0.
REQ-021 Reset mid-STEP or mid-OUT SHALL abort the item with no item_valid_o pulse; the next request SHALL take the reload path.

Structure
REQ-022 The FSM state enum (IDLE/STEP/OUT) SHALL be defined in shared package ca90_item_pkg.
REQ-023 The CA90 step SHALL be one instance of fixed_ca90_unit (Dimension = HVDimension, ShiftAmt = ShiftAmt), fed by state_q.

Verification
REQ-024 base_hv_i = 1 (bit0 only), req idx 0 -> item_valid_o 1 cycle after accept, item_hv_o = 1.
REQ-025 Same base, req idx 1 after reset -> valid 2 cycles after accept, item_hv_o has only bits 1 and 511 set.
REQ-026 Random base, req 3 then req 5 -> second item valid 3 cycles after accept (2 steps); then req 2 -> reload, valid 3 cycles after accept; all items match the reference model.
REQ-027 item_ready_i held low 10 cycles in OUT -> item_valid_o and item_hv_o stable, req_ready_o = 0 throughout.
REQ-028 base_update_i pulsed mid-STEP for req 6, then req 7 -> first item uses the old base; second reloads and takes 7 steps (valid 8 cycles after accept).
REQ-029 rst_i asserted mid-STEP -> no valid pulse; all outputs at reset values; next req 0 returns base_hv_i.
